// File: rtl/ad9637_spi_master_if.sv
// Command-side bundle between the AD9637 register block and the SPI serialiser.
// The register block drives the request; the serialiser returns status and read data.
interface ad9637_spi_master_if;
  logic        start;
  logic        rw;
  logic [12:0] addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;

  modport master (
    output start, rw, addr, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  start, rw, addr, wdata,
    output busy, done, rdata
  );
endinterface

// File: rtl/ad9637_spi_master.sv
// Runs one 24-bit 3-wire SPI frame to the AD9637 per accepted register command,
// returning the read byte and a one-cycle completion pulse.
module ad9637_spi_master #(
  parameter int CLK_DIV    = 10,
  parameter int GAP_HALVES = 2
) (
  input  logic                ACLK,
  input  logic                ARESET,
  ad9637_spi_master_if.slave  cmd,
  output logic                spi_csb,
  output logic                spi_sclk,
  output logic                spi_sdio_o,
  output logic                spi_sdio_oe,
  input  logic                spi_sdio_i
);

  localparam logic [15:0] HALF_LOAD = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_HALVES * CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [4:0]  bit_idx, bit_idx_n;
  logic [23:0] sr, sr_n;
  logic [7:0]  rx, rx_n;
  logic [7:0]  rdata_q, rdata_n;
  logic        rw_q, rw_n;
  logic        csb_n, sclk_n, oe_n;
  logic        last;

  assign last = (cnt == 16'd0);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      bit_idx     <= 5'd0;
      sr          <= 24'd0;
      rx          <= 8'd0;
      rdata_q     <= 8'd0;
      rw_q        <= 1'b0;
      spi_csb     <= 1'b1;
      spi_sclk    <= 1'b0;
      spi_sdio_oe <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      sr          <= sr_n;
      rx          <= rx_n;
      rdata_q     <= rdata_n;
      rw_q        <= rw_n;
      spi_csb     <= csb_n;
      spi_sclk    <= sclk_n;
      spi_sdio_oe <= oe_n;
    end
  end

  // Pin outputs are registered from next-state values so SCLK/CSB/OE never glitch.
  always_comb begin
    state_n   = state;
    cnt_n     = last ? cnt : cnt - 16'd1;
    bit_idx_n = bit_idx;
    sr_n      = sr;
    rx_n      = rx;
    rdata_n   = rdata_q;
    rw_n      = rw_q;
    csb_n     = spi_csb;
    sclk_n    = spi_sclk;
    oe_n      = spi_sdio_oe;

    case (state)
      IDLE: begin
        cnt_n = 16'd0;
        if (cmd.start) begin
          state_n   = SETUP;
          cnt_n     = HALF_LOAD;
          bit_idx_n = 5'd0;
          sr_n      = {cmd.rw, 2'b00, cmd.addr, cmd.wdata};
          rx_n      = 8'd0;
          rw_n      = cmd.rw;
          csb_n     = 1'b0;
          sclk_n    = 1'b0;
          oe_n      = 1'b1;
        end
      end
      SETUP: begin
        if (last) begin
          state_n = SHIFT_HI;
          cnt_n   = HALF_LOAD;
          sclk_n  = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (last) begin
          cnt_n  = HALF_LOAD;
          sclk_n = 1'b0;
          if (rw_q && bit_idx >= 5'd16) begin
            rx_n = {rx[6:0], spi_sdio_i};
          end
          if (bit_idx == 5'd23) begin
            state_n = HOLD;
          end else begin
            state_n   = SHIFT_LO;
            bit_idx_n = bit_idx + 5'd1;
            sr_n      = {sr[22:0], 1'b0};
            // Read turnaround: release SDIO once the 16-bit header has been clocked out.
            if (rw_q && bit_idx == 5'd15) begin
              oe_n = 1'b0;
            end
          end
        end
      end
      SHIFT_LO: begin
        if (last) begin
          state_n = SHIFT_HI;
          cnt_n   = HALF_LOAD;
          sclk_n  = 1'b1;
        end
      end
      HOLD: begin
        if (last) begin
          state_n = GAP;
          cnt_n   = GAP_LOAD;
          csb_n   = 1'b1;
          oe_n    = 1'b0;
          sr_n    = 24'd0;
        end
      end
      GAP: begin
        // Publish the read byte so it is already valid in the done cycle.
        if (cnt == 16'd1 && rw_q) begin
          rdata_n = rx;
        end
        if (last) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign spi_sdio_o = sr[23];
  assign cmd.busy   = (state != IDLE);
  assign cmd.done   = (state == GAP) && last;
  assign cmd.rdata  = rdata_q;

endmodule

// File: tb/tb_ad9637_spi_master.sv
// Self-checking bench: two serialisers (CLK_DIV=10/GAP=2 and CLK_DIV=2/GAP=1) checked
// every cycle against a frame-timeline model, an SPI decoder and an AD9637 read responder.
module tb_ad9637_spi_master;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;

  ad9637_spi_master_if cmd_a ();
  ad9637_spi_master_if cmd_b ();

  logic csb_a, sclk_a, sdo_a, oe_a;
  logic csb_b, sclk_b, sdo_b, oe_b;
  logic sdi_a = 1'b0;
  logic sdi_b = 1'b0;

  ad9637_spi_master #(.CLK_DIV(10), .GAP_HALVES(2)) dut_a (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .cmd         (cmd_a),
    .spi_csb     (csb_a),
    .spi_sclk    (sclk_a),
    .spi_sdio_o  (sdo_a),
    .spi_sdio_oe (oe_a),
    .spi_sdio_i  (sdi_a)
  );

  ad9637_spi_master #(.CLK_DIV(2), .GAP_HALVES(1)) dut_b (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .cmd         (cmd_b),
    .spi_csb     (csb_b),
    .spi_sclk    (sclk_b),
    .spi_sdio_o  (sdo_b),
    .spi_sdio_oe (oe_b),
    .spi_sdio_i  (sdi_b)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int timeout_cnt = 0;
  int exp_frames [2];
  logic final_req = 1'b0;
  logic final_ack = 1'b0;

  // Literal expectations attached by the stimulus to the next accepted frame.
  logic        stim_has_lit [2];
  logic [23:0] stim_lit [2];
  logic        stim_has_lrd [2];
  logic [7:0]  stim_lrd [2];
  logic [7:0]  stim_adc [2];

  function automatic int divOf(input int l);
    return (l == 0) ? 10 : 2;
  endfunction

  function automatic int gapOf(input int l);
    return (l == 0) ? 2 : 1;
  endfunction

  // Busy length: setup half + 47 shift halves + hold half + gap halves.
  function automatic int latOf(input int l);
    return (1 + 48 + gapOf(l)) * divOf(l);
  endfunction

  function automatic int busyLit(input int l);
    return (l == 0) ? 510 : 100;
  endfunction

  function automatic logic laneBusy(input int l);
    return (l == 0) ? cmd_a.busy : cmd_b.busy;
  endfunction

  function automatic logic laneDone(input int l);
    return (l == 0) ? cmd_a.done : cmd_b.done;
  endfunction

  task checkOutput(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s lane%0d t=%0t: got 0x%0h, required 0x%0h", name, lane, $time, act, exp);
    end
  endtask

  // Reference model, SPI decoder and ADC responder, all evaluated mid-cycle.
  int          rem [2];
  int          rises [2];
  int          busy_cnt [2];
  int          done_count [2];
  logic        cur_rw [2];
  logic [23:0] cur_word [2];
  logic        cur_has_lit [2];
  logic [23:0] cur_lit [2];
  logic        cur_has_lrd [2];
  logic [7:0]  cur_lrd [2];
  logic [7:0]  cur_adc [2];
  logic [7:0]  adc_sh [2];
  logic [7:0]  model_rdata [2];
  logic [23:0] dec [2];
  logic        prev_sclk [2];
  logic        prev_csb [2];
  logic        prev_busy [2];

  initial begin
    for (int l = 0; l < 2; l++) begin
      rem[l] = 0; rises[l] = 0; busy_cnt[l] = 0; done_count[l] = 0;
      cur_rw[l] = 1'b0; cur_word[l] = 24'd0; cur_has_lit[l] = 1'b0; cur_lit[l] = 24'd0;
      cur_has_lrd[l] = 1'b0; cur_lrd[l] = 8'd0; cur_adc[l] = 8'd0; adc_sh[l] = 8'd0;
      model_rdata[l] = 8'd0; dec[l] = 24'd0;
      prev_sclk[l] = 1'b0; prev_csb[l] = 1'b1; prev_busy[l] = 1'b0;
    end
    forever begin
      @(negedge ACLK);
      for (int l = 0; l < 2; l++) begin
        logic v_csb, v_sclk, v_sdo, v_oe, v_busy, v_done, v_start, v_rw;
        logic [7:0]  v_rdata, v_wdata;
        logic [12:0] v_addr;
        logic e_busy, e_done, e_csb, e_sclk, e_oe;
        int d, lat, el, ph;
        v_csb   = (l == 0) ? csb_a : csb_b;
        v_sclk  = (l == 0) ? sclk_a : sclk_b;
        v_sdo   = (l == 0) ? sdo_a : sdo_b;
        v_oe    = (l == 0) ? oe_a : oe_b;
        v_busy  = (l == 0) ? cmd_a.busy : cmd_b.busy;
        v_done  = (l == 0) ? cmd_a.done : cmd_b.done;
        v_rdata = (l == 0) ? cmd_a.rdata : cmd_b.rdata;
        v_start = (l == 0) ? cmd_a.start : cmd_b.start;
        v_rw    = (l == 0) ? cmd_a.rw : cmd_b.rw;
        v_addr  = (l == 0) ? cmd_a.addr : cmd_b.addr;
        v_wdata = (l == 0) ? cmd_a.wdata : cmd_b.wdata;
        d   = divOf(l);
        lat = latOf(l);

        if (ARESET) begin
          rem[l] = 0; rises[l] = 0; busy_cnt[l] = 0; dec[l] = 24'd0;
          cur_rw[l] = 1'b0; model_rdata[l] = 8'd0;
          if (l == 0) sdi_a = 1'b0; else sdi_b = 1'b0;
        end

        // Frame timeline: elapsed half-periods decide SCLK level, CSB window and OE window.
        e_busy = (rem[l] > 0);
        e_done = (rem[l] == 1);
        el     = lat - rem[l];
        ph     = el / d;
        e_csb  = !(e_busy && el < 49 * d);
        e_sclk = e_busy && (el < 48 * d) && (ph % 2 == 1);
        e_oe   = !e_csb && (!cur_rw[l] || ph < 32);

        checkOutput("busy", l, 32'(v_busy), 32'(e_busy));
        checkOutput("done", l, 32'(v_done), 32'(e_done));
        checkOutput("csb", l, 32'(v_csb), 32'(e_csb));
        checkOutput("sclk", l, 32'(v_sclk), 32'(e_sclk));
        checkOutput("sdio_oe", l, 32'(v_oe), 32'(e_oe));
        checkOutput("rdata", l, 32'(v_rdata), 32'(model_rdata[l]));
        if (ARESET) checkOutput("sdio_o_reset", l, 32'(v_sdo), 32'd0);

        if (!ARESET) begin
          if (!prev_sclk[l] && v_sclk) begin
            dec[l] = {dec[l][22:0], v_sdo};
            rises[l]++;
          end
          if (prev_sclk[l] && !v_sclk && !v_csb && cur_rw[l] && rises[l] >= 16 && rises[l] < 24) begin
            if (l == 0) sdi_a = adc_sh[l][7]; else sdi_b = adc_sh[l][7];
            adc_sh[l] = {adc_sh[l][6:0], 1'b0};
          end
          if (!prev_csb[l] && v_csb) begin
            checkOutput("sclk_rises", l, 32'(rises[l]), 32'd24);
            if (cur_rw[l]) begin
              checkOutput("read_header", l, 32'(dec[l][23:8]), 32'(cur_word[l][23:8]));
              if (cur_has_lit[l]) checkOutput("read_header_lit", l, 32'(dec[l][23:8]), 32'(cur_lit[l][23:8]));
            end else begin
              checkOutput("write_frame", l, 32'(dec[l]), 32'(cur_word[l]));
              if (cur_has_lit[l]) checkOutput("write_frame_lit", l, 32'(dec[l]), 32'(cur_lit[l]));
            end
            rises[l] = 0;
          end
          if (prev_busy[l] && !v_busy) checkOutput("busy_len", l, 32'(busy_cnt[l]), 32'(busyLit(l)));
          busy_cnt[l] = v_busy ? busy_cnt[l] + 1 : 0;
          if (v_done) begin
            done_count[l]++;
            if (cur_has_lrd[l]) checkOutput("rdata_lit", l, 32'(v_rdata), 32'(cur_lrd[l]));
          end

          // Advance to the next cycle: start is only honoured when no frame is pending.
          if (rem[l] > 0) begin
            rem[l]--;
          end else if (v_start) begin
            rem[l]         = lat;
            cur_rw[l]      = v_rw;
            cur_word[l]    = {v_rw, 2'b00, v_addr, v_wdata};
            cur_has_lit[l] = stim_has_lit[l];
            cur_lit[l]     = stim_lit[l];
            cur_has_lrd[l] = stim_has_lrd[l];
            cur_lrd[l]     = stim_lrd[l];
            cur_adc[l]     = stim_adc[l];
            adc_sh[l]      = stim_adc[l];
          end
          if (rem[l] == 1 && cur_rw[l]) model_rdata[l] = cur_adc[l];
        end

        prev_sclk[l] = v_sclk;
        prev_csb[l]  = v_csb;
        prev_busy[l] = v_busy;
      end

      if (final_req && !final_ack) begin
        for (int l = 0; l < 2; l++) checkOutput("done_count", l, 32'(done_count[l]), 32'(exp_frames[l]));
        checkOutput("timeouts", 0, 32'(timeout_cnt), 32'd0);
        final_ack = 1'b1;
      end
    end
  end

  task automatic driveCmd(input int l, input logic s, input logic r, input logic [12:0] a, input logic [7:0] w);
    if (l == 0) begin
      cmd_a.start = s; cmd_a.rw = r; cmd_a.addr = a; cmd_a.wdata = w;
    end else begin
      cmd_b.start = s; cmd_b.rw = r; cmd_b.addr = a; cmd_b.wdata = w;
    end
  endtask

  // Holds start until the serialiser accepts it; called mid-cycle (just after a rising edge).
  task automatic applyStimulus(input int l, input logic r, input logic [12:0] a, input logic [7:0] w,
                               input logic [7:0] adc, input logic has_lit, input logic [23:0] lit,
                               input logic has_lrd, input logic [7:0] lrd);
    logic accepted;
    accepted = 1'b0;
    stim_has_lit[l] = has_lit;
    stim_lit[l]     = lit;
    stim_has_lrd[l] = has_lrd;
    stim_lrd[l]     = lrd;
    stim_adc[l]     = adc;
    driveCmd(l, 1'b1, r, a, w);
    for (int n = 0; n < 20 && !accepted; n++) begin
      @(posedge ACLK);
      #1;
      if (laneBusy(l)) accepted = 1'b1;
    end
    driveCmd(l, 1'b0, r, a, w);
    if (!accepted) timeout_cnt++;
  endtask

  task automatic waitDone(input int l);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 700 && !seen; n++) begin
      @(posedge ACLK);
      #1;
      if (laneDone(l)) seen = 1'b1;
    end
    if (seen) exp_frames[l]++;
    else timeout_cnt++;
  endtask

  task automatic randomFrames(input int l, input int n);
    for (int i = 0; i < n; i++) begin
      logic r;
      logic [12:0] a;
      logic [7:0] w, q;
      r = 1'($urandom_range(0, 1));
      a = 13'($urandom);
      w = 8'($urandom);
      q = 8'($urandom);
      repeat ($urandom_range(0, 3)) begin
        @(posedge ACLK);
        #1;
      end
      applyStimulus(l, r, a, w, q, 1'b0, 24'd0, 1'b0, 8'd0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(2, latOf(l) - 20)) begin
          @(posedge ACLK);
          #1;
        end
        driveCmd(l, 1'b1, 1'($urandom_range(0, 1)), 13'($urandom), 8'($urandom));
        @(posedge ACLK);
        #1;
        driveCmd(l, 1'b0, 1'($urandom_range(0, 1)), 13'($urandom), 8'($urandom));
      end
      waitDone(l);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_rise;
    logic prev;
    exp_frames[0] = 0;
    exp_frames[1] = 0;
    for (int l = 0; l < 2; l++) begin
      stim_has_lit[l] = 1'b0; stim_lit[l] = 24'd0;
      stim_has_lrd[l] = 1'b0; stim_lrd[l] = 8'd0; stim_adc[l] = 8'd0;
    end
    driveCmd(0, 1'b0, 1'b0, 13'd0, 8'd0);
    driveCmd(1, 1'b0, 1'b0, 13'd0, 8'd0);
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    repeat (2) begin
      @(posedge ACLK);
      #1;
    end

    $display("[TB] directed write 0x008/0x03");
    applyStimulus(0, 1'b0, 13'h008, 8'h03, 8'h00, 1'b1, 24'h000803, 1'b0, 8'h00);
    waitDone(0);

    $display("[TB] directed read 0x001, ADC returns 0x91");
    applyStimulus(0, 1'b1, 13'h001, 8'h00, 8'h91, 1'b1, 24'h800100, 1'b1, 8'h91);
    waitDone(0);

    $display("[TB] start while busy");
    applyStimulus(0, 1'b0, 13'h010, 8'h5A, 8'h00, 1'b1, 24'h00105A, 1'b0, 8'h00);
    repeat (100) begin
      @(posedge ACLK);
      #1;
    end
    driveCmd(0, 1'b1, 1'b0, 13'h0FF, 8'h77);
    @(posedge ACLK);
    #1;
    driveCmd(0, 1'b0, 1'b0, 13'h0FF, 8'h77);
    waitDone(0);

    $display("[TB] reset after the 10th SCLK rising edge");
    applyStimulus(0, 1'b0, 13'h020, 8'hC3, 8'h00, 1'b1, 24'h0020C3, 1'b0, 8'h00);
    n_rise = 0;
    prev = sclk_a;
    for (int n = 0; n < 400 && n_rise < 10; n++) begin
      @(posedge ACLK);
      #1;
      if (!prev && sclk_a) n_rise++;
      prev = sclk_a;
    end
    if (n_rise < 10) timeout_cnt++;
    ARESET = 1'b1;
    repeat (3) begin
      @(posedge ACLK);
      #1;
    end
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    applyStimulus(0, 1'b0, 13'h021, 8'h3C, 8'h00, 1'b1, 24'h00213C, 1'b0, 8'h00);
    waitDone(0);

    $display("[TB] back-to-back writes on the fast instance");
    applyStimulus(1, 1'b0, 13'h014, 8'hAA, 8'h00, 1'b1, 24'h0014AA, 1'b0, 8'h00);
    waitDone(1);
    @(posedge ACLK);
    #1;
    applyStimulus(1, 1'b0, 13'h015, 8'h55, 8'h00, 1'b1, 24'h001555, 1'b0, 8'h00);
    waitDone(1);

    $display("[TB] randomized frames on both instances");
    fork
      randomFrames(0, 6);
      randomFrames(1, 20);
    join

    repeat (5) begin
      @(posedge ACLK);
      #1;
    end
    final_req = 1'b1;
    for (int n = 0; n < 10 && !final_ack; n++) @(posedge ACLK);
    if (!final_ack) $display("[TB] FAIL final_handshake: got 0, required 1");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
